// File: rtl/gpio_in_debounce_if.sv
// Bundles the board-input conditioning signals between pins, debouncer and PIO_IN.
// The slave modport is the debouncer side; the master side drives pins and clears.
interface gpio_in_debounce_if #(
  parameter int unsigned WIDTH = 14
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] edge_capture;

  modport master (
    output raw_in,
    output edge_clear,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  edge_capture
  );

  modport slave (
    input  raw_in,
    input  edge_clear,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output edge_capture
  );
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-bit 2-flop synchronizer, stable-count debouncer and rise/fall pulse generator.
// Optional sticky edge capture enabled by defining GPIO_DB_EDGE_CAPTURE_EN.
module gpio_in_debounce #(
  parameter int unsigned     WIDTH           = 14,
  parameter int unsigned     DEBOUNCE_CYCLES = 250000,
  parameter logic [WIDTH-1:0] RESET_VAL      = WIDTH'(14'h000F)
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  gpio_in_debounce_if.slave   bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_cnt     [WIDTH];

  logic [WIDTH-1:0] w_db_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

  // Synchronizer: only r_sync2 is used downstream
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Any return to the current level discards the partial count
  always_comb begin
    w_db_nxt  = r_db;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (r_sync2[i] == r_db[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_db_nxt[i]  = r_sync2[i];
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_db   <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db   <= w_db_nxt;
      r_rise <= w_db_nxt & ~r_db;
      r_fall <= ~w_db_nxt & r_db;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.db_out     = r_db;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;

`ifdef GPIO_DB_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] r_edge_cap;

  // A pulse landing on the same edge as a clear keeps the flag set
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~bus.edge_clear) | r_rise | r_fall;
    end
  end

  assign bus.edge_capture = r_edge_cap;
`else
  logic w_unused_edge_clear;
  assign w_unused_edge_clear = ^bus.edge_clear;
  assign bus.edge_capture    = '0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed, table-driven check of gpio_in_debounce with DEBOUNCE_CYCLES=4.
// Edge-capture expectations follow GPIO_DB_EDGE_CAPTURE_EN.
module tb_gpio_in_debounce;

  localparam int unsigned W = 14;

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] clr;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t tbl[$];
  logic [W-1:0] m_cap;
  logic [W-1:0] m_prev_pulse;

`ifdef GPIO_DB_EDGE_CAPTURE_EN
  localparam logic CAP_ON = 1'b1;
`else
  localparam logic CAP_ON = 1'b0;
`endif

  gpio_in_debounce_if #(.WIDTH(W)) bus ();

  gpio_in_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4),
    .RESET_VAL       (14'h000F)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] raw, input logic [W-1:0] db,
                      input logic [W-1:0] rise, input logic [W-1:0] fall);
    vec_t v;
    v.raw = raw; v.clr = '0; v.db = db; v.rise = rise; v.fall = fall;
    tbl.push_back(v);
  endtask

  task automatic hold(input logic [W-1:0] raw, input logic [W-1:0] db, input int n);
    for (int k = 0; k < n; k++) push(raw, db, '0, '0);
  endtask

  // Each raw change reaches db_out on the 6th edge: 2 sync + 4 stable counts
  task automatic step_to(input logic [W-1:0] raw, input logic [W-1:0] db_old,
                         input logic [W-1:0] db_new);
    hold(raw, db_old, 5);
    push(raw, db_new, db_new & ~db_old, db_old & ~db_new);
    hold(raw, db_new, 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    m_cap        = '0;
    m_prev_pulse = '0;
    rst_n        = 1'b0;
    bus.raw_in     = 14'h000F;
    bus.edge_clear = '0;

    // Vector table
    hold(14'h000F, 14'h000F, 20);
    step_to(14'h000D, 14'h000F, 14'h000D);
    hold(14'h002D, 14'h000D, 3);
    hold(14'h000D, 14'h000D, 5);
    step_to(14'h002D, 14'h000D, 14'h002D);
    step_to(14'h000F, 14'h002D, 14'h000F);
    step_to(14'h3FF0, 14'h000F, 14'h3FF0);
    step_to(14'h000F, 14'h3FF0, 14'h000F);

    cyc(3);
    chk("reset_db",   bus.db_out,       14'h000F);
    chk("reset_rise", bus.rise_pulse,   '0);
    chk("reset_fall", bus.fall_pulse,   '0);
    chk("reset_cap",  bus.edge_capture, '0);
    rst_n = 1'b1;

    foreach (tbl[j]) begin
      bus.raw_in     = tbl[j].raw;
      bus.edge_clear = tbl[j].clr;
      @(negedge clk);
      m_cap        = CAP_ON ? ((m_cap & ~tbl[j].clr) | m_prev_pulse) : '0;
      m_prev_pulse = tbl[j].rise | tbl[j].fall;
      chk($sformatf("vec%0d_db", j),   bus.db_out,       tbl[j].db);
      chk($sformatf("vec%0d_rise", j), bus.rise_pulse,   tbl[j].rise);
      chk($sformatf("vec%0d_fall", j), bus.fall_pulse,   tbl[j].fall);
      chk($sformatf("vec%0d_cap", j),  bus.edge_capture, m_cap);
    end

    // Edge capture: clear everything, then set/clear interaction on bit 2
    bus.edge_clear = '1;
    cyc(1);
    bus.edge_clear = '0;
    chk("cap_cleared", bus.edge_capture, '0);
    bus.raw_in = 14'h000B;
    cyc(6);
    chk("cap_fall2", bus.fall_pulse, 14'h0004);
    cyc(1);
    chk("cap_set",   bus.edge_capture, CAP_ON ? 14'h0004 : 14'h0000);
    bus.raw_in = 14'h000F;
    cyc(6);
    chk("cap_rise2", bus.rise_pulse, 14'h0004);
    bus.edge_clear = 14'h0004;
    cyc(1);
    chk("cap_set_wins", bus.edge_capture, CAP_ON ? 14'h0004 : 14'h0000);
    cyc(1);
    chk("cap_clr_only", bus.edge_capture, '0);
    bus.edge_clear = '0;

    // Reset in the middle of a count
    bus.raw_in = 14'h000E;
    cyc(3);
    chk("midcnt_db", bus.db_out, 14'h000F);
    rst_n = 1'b0;
    #1;
    chk("midrst_db",   bus.db_out,     14'h000F);
    chk("midrst_fall", bus.fall_pulse, '0);
    bus.raw_in = 14'h000F;
    cyc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk($sformatf("post_rst%0d_db", k),   bus.db_out,     14'h000F);
      chk($sformatf("post_rst%0d_fall", k), bus.fall_pulse, '0);
    end
    // Full latency again confirms no partial credit survived reset
    bus.raw_in = 14'h000E;
    cyc(5);
    chk("relat_db_early", bus.db_out, 14'h000F);
    cyc(1);
    chk("relat_db",   bus.db_out,     14'h000E);
    chk("relat_fall", bus.fall_pulse, 14'h0001);
    cyc(1);
    chk("relat_fall_end", bus.fall_pulse, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
